// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared op codes, FSM states, widths and constant codes for reg_bank and its sequencer
package reg_bank_pkg;

    localparam int BANK_DATA_W = 64;
    localparam int BANK_ADDR_W = 4;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ_A = 2'b01,
        OP_READ_B = 2'b10,
        OP_CNST_B = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SETUP,
        ENABLE,
        CAPTURE,
        RESP
    } state_e;

    localparam logic [3:0] CNST_ZERO     = 4'b0000;
    localparam logic [3:0] CNST_HI_ONE   = 4'b1000;
    localparam logic [3:0] CNST_ONE      = 4'b0100;
    localparam logic [3:0] CNST_LO_MASK  = 4'b0101;
    localparam logic [3:0] CNST_HI_MASK  = 4'b1010;
    localparam logic [3:0] CNST_ALL_ONES = 4'b1111;
    localparam logic [3:0] CNST_NOT_ONE2 = 4'b0011;

    // Value reg_bank drives when cnstB selects a constant code
    function automatic logic [63:0] cnst_value(input logic [3:0] code);
        case (code)
            CNST_HI_ONE:   return 64'h00000001_00000000;
            CNST_ONE:      return 64'h00000000_00000001;
            CNST_LO_MASK:  return 64'h00000000_FFFFFFFF;
            CNST_HI_MASK:  return 64'hFFFFFFFF_00000000;
            CNST_ALL_ONES: return 64'hFFFFFFFF_FFFFFFFF;
            CNST_NOT_ONE2: return 64'hFFFFFFFE_FFFFFFFE;
            default:       return 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/reg_bank_seq_cnt.sv
// reg_bank_seq_cnt: loadable down-counter that times the write hold and read settle phases
module reg_bank_seq_cnt
    import reg_bank_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    // Load wins over decrement; the count parks at zero instead of wrapping
    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !zero)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/reg_bank_seq.sv
// reg_bank_seq: sequences reg_bank write/read/constant strobes from a valid/ready command stream.
// Optional REG_BANK_SEQ_WACK_EN: writes also return a response flagged by rsp_wack.
module reg_bank_seq
    import reg_bank_pkg::*;
#(
    parameter int DATA_W    = BANK_DATA_W,
    parameter int ADDR_W    = BANK_ADDR_W,
    parameter int WR_CYCLES = 2,
    parameter int RD_SETTLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_endreg,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
`ifdef REG_BANK_SEQ_WACK_EN
    output logic              rsp_wack,
`endif
    output logic              regwe,
    output logic [DATA_W-1:0] inA,
    output logic [ADDR_W-1:0] selwreg,
    output logic [1:0]        endreg,
    output logic [ADDR_W-1:0] seloutA,
    output logic [ADDR_W-1:0] seloutB,
    output logic              cnstA,
    output logic              cnstB,
    output logic              enrregA,
    output logic              enrregB,
    input  logic [DATA_W-1:0] outA,
    input  logic [DATA_W-1:0] outB
);

    state_e            state;
    op_e               op_q;
    logic              accept;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready;

    reg_bank_seq_cnt #(.W(CNT_W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .dec      (state == WRITE || state == SETUP),
        .load_val (op_e'(cmd_op) == OP_WRITE ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_SETTLE - 1)),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Command FSM: every bank strobe and handshake output is a flop driven from here
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= OP_WRITE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef REG_BANK_SEQ_WACK_EN
            rsp_wack  <= 1'b0;
`endif
            regwe     <= 1'b0;
            inA       <= '0;
            selwreg   <= '0;
            endreg    <= '0;
            seloutA   <= '0;
            seloutB   <= '0;
            cnstA     <= 1'b0;
            cnstB     <= 1'b0;
            enrregA   <= 1'b0;
            enrregB   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        op_q      <= op_e'(cmd_op);
                        case (op_e'(cmd_op))
                            OP_WRITE: begin
                                regwe   <= 1'b1;
                                inA     <= cmd_data;
                                selwreg <= cmd_addr;
                                endreg  <= cmd_endreg;
                                state   <= WRITE;
                            end
                            OP_READ_A: begin
                                seloutA <= cmd_addr;
                                state   <= SETUP;
                            end
                            default: begin
                                seloutB <= cmd_addr;
                                cnstB   <= (op_e'(cmd_op) == OP_CNST_B);
                                state   <= SETUP;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (cnt_zero) begin
                        regwe <= 1'b0;
`ifdef REG_BANK_SEQ_WACK_EN
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_wack  <= 1'b1;
                        state     <= RESP;
`else
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
`endif
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        enrregA <= (op_q == OP_READ_A);
                        enrregB <= (op_q != OP_READ_A);
                        state   <= ENABLE;
                    end
                end
                ENABLE: begin
                    enrregA <= 1'b0;
                    enrregB <= 1'b0;
                    cnstB   <= 1'b0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data  <= (op_q == OP_READ_A) ? outA : outB;
                    rsp_valid <= 1'b1;
`ifdef REG_BANK_SEQ_WACK_EN
                    rsp_wack  <= 1'b0;
`endif
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef REG_BANK_SEQ_WACK_EN
                        rsp_wack  <= 1'b0;
`endif
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_seq.sv
// tb_reg_bank_seq: directed and random commands against a reg_bank stand-in and a command-level memory model
module tb_reg_bank_seq;
    import reg_bank_pkg::*;

    localparam int DW  = 64;
    localparam int AW  = 4;
    localparam int WRC = 2;
    localparam int RDS = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [1:0]    cmd_endreg = 2'b00;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
`ifdef REG_BANK_SEQ_WACK_EN
    logic          rsp_wack;
`endif
    logic          regwe;
    logic [DW-1:0] inA;
    logic [AW-1:0] selwreg;
    logic [1:0]    endreg;
    logic [AW-1:0] seloutA;
    logic [AW-1:0] seloutB;
    logic          cnstA;
    logic          cnstB;
    logic          enrregA;
    logic          enrregB;
    logic [DW-1:0] outA = '0;
    logic [DW-1:0] outB = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] bank [16] = '{default: '0};
    logic [63:0] mem  [16] = '{default: '0};
    logic [3:0]  codes [7] = '{4'b0000, 4'b1000, 4'b0100, 4'b0101, 4'b1010, 4'b1111, 4'b0011};

    always #5 clock = ~clock;

    reg_bank_seq #(.DATA_W(DW), .ADDR_W(AW), .WR_CYCLES(WRC), .RD_SETTLE(RDS)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_endreg (cmd_endreg),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
`ifdef REG_BANK_SEQ_WACK_EN
        .rsp_wack   (rsp_wack),
`endif
        .regwe      (regwe),
        .inA        (inA),
        .selwreg    (selwreg),
        .endreg     (endreg),
        .seloutA    (seloutA),
        .seloutB    (seloutB),
        .cnstA      (cnstA),
        .cnstB      (cnstB),
        .enrregA    (enrregA),
        .enrregB    (enrregB),
        .outA       (outA),
        .outB       (outB)
    );

    function automatic logic [63:0] cnst_ref(input logic [3:0] c);
        case (c)
            4'b1000: return 64'h00000001_00000000;
            4'b0100: return 64'h00000000_00000001;
            4'b0101: return 64'h00000000_FFFFFFFF;
            4'b1010: return 64'hFFFFFFFF_00000000;
            4'b1111: return 64'hFFFFFFFF_FFFFFFFF;
            4'b0011: return 64'hFFFFFFFE_FFFFFFFE;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] wr_value(input logic [1:0] er, input logic [63:0] d);
        return (er == 2'b11) ? {d[31:0], d[63:32]} : d;
    endfunction

    // reg_bank stand-in: writes while regwe, registers outA/outB when the enables are sampled high
    always @(posedge clock) begin
        if (regwe)
            bank[selwreg] <= wr_value(endreg, inA);
        if (enrregA)
            outA <= bank[seloutA];
        if (enrregB)
            outB <= cnstB ? cnst_ref(seloutB) : bank[seloutB];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_ctrl", 64'({cmd_ready, rsp_valid, regwe, cnstA, cnstB, enrregA, enrregB,
                             selwreg, endreg, seloutA, seloutB}), 64'h0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        chk("rst_inA", inA, 64'h0);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [1:0] er,
                        input logic [63:0] data);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait_timeout", 64'(n < 50), 64'h1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_addr   = addr;
        cmd_endreg = er;
        cmd_data   = data;
        @(negedge clock);
        cmd_valid  = 1'b0;
        cmd_data   = {$urandom, $urandom};
        cmd_addr   = 4'($urandom);
        chk("accept_ready_drop", 64'(cmd_ready), 64'h0);
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [1:0] er, input logic [63:0] data);
        send(OP_WRITE, addr, er, data);
        mem[addr] = wr_value(er, data);
        chk("wr_fields", {inA}, data);
        chk("wr_sel", 64'({selwreg, endreg}), 64'({addr, er}));
        for (int i = 0; i < WRC; i++) begin
            chk("regwe_high", 64'(regwe), 64'h1);
            chk("wr_no_rsp", 64'(rsp_valid), 64'h0);
            @(negedge clock);
        end
        chk("regwe_low", 64'(regwe), 64'h0);
`ifdef REG_BANK_SEQ_WACK_EN
        chk("wack_valid", 64'(rsp_valid), 64'h1);
        chk("wack_flag", 64'(rsp_wack), 64'h1);
        chk("wack_data", rsp_data, 64'h0);
        chk("wack_ready_low", 64'(cmd_ready), 64'h0);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("wack_done_valid", 64'(rsp_valid), 64'h0);
        chk("wack_done_ready", 64'(cmd_ready), 64'h1);
`else
        chk("wr_no_rsp_end", 64'(rsp_valid), 64'h0);
        chk("wr_ready_back", 64'(cmd_ready), 64'h1);
`endif
    endtask

    task automatic do_read(input logic [1:0] op, input logic [3:0] addr, input int hold, input bit stray);
        logic [63:0] exp;
        logic [1:0]  enr_exp;
        exp     = (op == OP_CNST_B) ? cnst_ref(addr) : mem[addr];
        enr_exp = (op == OP_READ_A) ? 2'b10 : 2'b01;
        rsp_ready = (hold == 0);
        send(op, addr, 2'b00, {$urandom, $urandom});
        for (int i = 0; i < RDS; i++) begin
            chk("setup_enr_low", 64'({enrregA, enrregB}), 64'h0);
            chk("setup_cnstB", 64'(cnstB), 64'(op == OP_CNST_B));
            @(negedge clock);
        end
        chk("enable_enr", 64'({enrregA, enrregB}), 64'(enr_exp));
        chk("enable_cnstB", 64'(cnstB), 64'(op == OP_CNST_B));
        chk("read_sel", 64'((op == OP_READ_A) ? seloutA : seloutB), 64'(addr));
        @(negedge clock);
        chk("capture_enr_low", 64'({enrregA, enrregB, cnstB}), 64'h0);
        chk("capture_no_rsp", 64'(rsp_valid), 64'h0);
        @(negedge clock);
        chk("rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rsp_data", rsp_data, exp);
`ifdef REG_BANK_SEQ_WACK_EN
        chk("rsp_wack_read", 64'(rsp_wack), 64'h0);
`endif
        for (int i = 0; i < hold; i++) begin
            if (stray) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_WRITE;
            end
            @(negedge clock);
            chk("stall_valid", 64'(rsp_valid), 64'h1);
            chk("stall_data", rsp_data, exp);
            chk("stall_ready", 64'(cmd_ready), 64'h0);
            chk("stall_no_write", 64'(regwe), 64'h0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_done_valid", 64'(rsp_valid), 64'h0);
        chk("rsp_done_ready", 64'(cmd_ready), 64'h1);
        chk("rsp_done_no_write", 64'(regwe), 64'h0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [63:0] data;
        repeat (3) @(negedge clock);
        chk_reset_state();
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 64'(cmd_ready), 64'h1);

        // reset while regwe is high
        send(OP_WRITE, 4'd7, 2'b00, 64'h0123_4567_89AB_CDEF);
        chk("midwr_regwe", 64'(regwe), 64'h1);
        mem[7] = 64'h0123_4567_89AB_CDEF;
        reset = 1'b0;
        @(negedge clock);
        chk_reset_state();
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_midwr_reset", 64'(cmd_ready), 64'h1);

        do_write(4'd5, 2'b00, 64'h4);
        do_read(OP_READ_A, 4'd5, 0, 1'b0);
        do_write(4'd5, 2'b11, 64'h00000001_00000002);
        do_read(OP_READ_A, 4'd5, 0, 1'b0);
        chk("swap_model", mem[5], 64'h00000002_00000001);
        do_read(OP_CNST_B, 4'b0000, 0, 1'b0);
        do_read(OP_CNST_B, 4'b0101, 0, 1'b0);
        do_read(OP_CNST_B, 4'b1010, 1, 1'b0);
        do_read(OP_CNST_B, 4'b0011, 0, 1'b0);
        do_read(OP_READ_B, 4'd7, 5, 1'b1);
        do_write(4'd3, 2'b00, 64'hDEAD_BEEF_0000_0003);
        do_read(OP_READ_B, 4'd3, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op   = 2'($urandom_range(0, 3));
            addr = 4'($urandom);
            data = {$urandom, $urandom};
            if (op == OP_WRITE)
                do_write(addr, $urandom_range(0, 1) ? 2'b11 : 2'b00, data);
            else if (op == OP_CNST_B)
                do_read(op, codes[$urandom_range(0, 6)], $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            else
                do_read(op, addr, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_seq.md
Name: reg_bank_seq

Overview:
- Sequencing controller, the initiator that drives reg_bank.
- Accepts write/read/constant commands on a valid/ready interface and generates the cycle-accurate regwe/enrregA/enrregB/cnstB strobe sequences that reg_bank needs.
- Captures outA/outB and returns the value on a valid/ready response channel.
- Sits between the datapath control unit and reg_bank, so the control unit never sequences bank strobes directly.

Parameters:
- DATA_W, 64: bank data width.
- ADDR_W, 4: register select width (16 registers).
- WR_CYCLES, 2: cycles regwe is held high per write (1..15).
- RD_SETTLE, 1: cycles between select/cnst setup and the enrreg pulse (1..7).

Ports:
- clock  in  1  master clock, posedge.
- reset  in  1  synchronous, active-low reset (asserted when reset=0, sampled on posedge clock).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 WRITE, 01 READ_A, 10 READ_B, 11 CNST_B.
- cmd_addr  in  ADDR_W  register index (WRITE/READ_A/READ_B) or constant code (CNST_B).
- cmd_endreg  in  2  endreg value for WRITE.
- cmd_data  in  DATA_W  write data.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  captured read value.
- regwe, inA[DATA_W], selwreg[ADDR_W], endreg[2]  out  bank write side.
- seloutA[ADDR_W], seloutB[ADDR_W], cnstA, cnstB, enrregA, enrregB  out  bank read side.
- outA, outB  in  DATA_W  bank read data.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at posedge): state IDLE. Every output is driven to 0, including cmd_ready, rsp_valid and all strobes. This also applies mid-operation: strobes drop at the same edge and the pending response is discarded.
- cmd_ready rises on the first edge after reset is released. It is 1 only in IDLE, and drops on the accept edge.
- Accept edge k (cmd_valid & cmd_ready): latch inA, selwreg, endreg, seloutA and seloutB from the command fields. Unused selects keep their previous value.
- WRITE:
  - regwe=1 after edge k, held for exactly WR_CYCLES cycles, cleared at edge k+WR_CYCLES.
  - cmd_ready=1 at that same edge.
  - No response is produced.
- READ_A:
  - State SETUP for RD_SETTLE cycles.
  - Then state ENABLE: enrregA=1 for exactly 1 cycle, so the bank registers outA on the edge where enrregA is sampled high.
  - Then state CAPTURE for 1 cycle: rsp_data<=outA, rsp_valid<=1.
  - With RD_SETTLE=1, rsp_valid is high after edge k+3.
- READ_B: identical to READ_A, using seloutB/enrregB/outB.
- CNST_B:
  - cnstB=1 from edge k, held through the ENABLE cycle, cleared with enrregB.
  - seloutB=cmd_addr.
  - Capture outB exactly as READ_B.
- State RESP:
  - rsp_valid held and rsp_data stable until rsp_valid & rsp_ready.
  - On that handshake edge: rsp_valid<=0, state IDLE, cmd_ready<=1.
  - If rsp_ready is already high on the first RESP cycle, the response lasts exactly 1 cycle.
- One command is in flight at a time; there is no command queue.
- cnstA is never asserted by this block and is tied to registered 0 (reserved for future use).
- Counters are sized to the parameter maxima. The counter reaching WR_CYCLES-1 or RD_SETTLE-1 triggers the transition; there is no wrap-around.
- A command held on cmd_valid while cmd_ready=0 is ignored until ready. Field changes during that time have no effect.

Optional Feature:
- REG_BANK_SEQ_WACK_EN defined: WRITE also enters RESP after regwe drops. rsp_data=0 and new output rsp_wack=1 (rsp_wack=0 for reads). cmd_ready returns only after the response handshake.
- Undefined: port rsp_wack does not exist, and WRITE returns to IDLE with no response.

Decomposition:
- Shared package reg_bank_pkg holds:
  - the op encodings (OP_WRITE=2'b00, OP_READ_A, OP_READ_B, OP_CNST_B);
  - the FSM state enum (IDLE, WRITE, SETUP, ENABLE, CAPTURE, RESP);
  - DATA_W/ADDR_W defaults.
- Constant codes reg_bank resolves: 0000→0, 1000→0x00000001_00000000, 0100→1, 0101→0x00000000_FFFFFFFF, 1010→0xFFFFFFFF_00000000, 1111→all ones, 0011→0xFFFFFFFE_FFFFFFFE. They go in the package for shared use by this block's bench and reg_bank's bench.
- One sub-module is natural: reg_bank_seq_cnt, a loadable down-counter used for the WR_CYCLES and RD_SETTLE delays.

Test Plan:
- Reset mid-WRITE (reset=0 while regwe=1): regwe=0 at that edge and all outputs are 0. cmd_ready=1 on the first edge after release.
- WRITE addr=5, data=0x4, endreg=00, then READ_A addr=5:
  - regwe high for 2 cycles;
  - enrregA pulse 1 cycle, 2 cycles after the read is accepted;
  - rsp_data=0x0000000000000004, 3 cycles after accept.
- WRITE addr=5, data=0x00000001_00000002, endreg=11, then READ_A: rsp_data=0x00000002_00000001.
- CNST_B codes 0000, 0101, 1010, 0011:
  - rsp_data = 0x0, 0x00000000FFFFFFFF, 0xFFFFFFFF00000000, 0xFFFFFFFEFFFFFFFE;
  - cnstB and enrregB fall on the same edge.
- READ_B with rsp_ready=0 for 5 cycles: rsp_valid and rsp_data stay stable and cmd_ready=0. When rsp_ready=1, rsp_valid=0 and cmd_ready=1 on the next edge. A new cmd_valid during the stall is not accepted.
- With REG_BANK_SEQ_WACK_EN: WRITE addr=3 gives rsp_valid=1, rsp_wack=1, rsp_data=0 after regwe drops. Without it: no rsp_valid pulse.
